// File: rtl/dispense_if.sv
// Purchase/restock/query/motor bundle between the buy-product front end and dispense_controller.
// With DISPENSE_SALES_COUNTER_EN defined the bundle also carries the 16-bit total_sold count.
interface dispense_if #(
    parameter int STOCK_W = 8
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         item_code;
    logic [3:0]         item_count;
    logic               restock_valid;
    logic [2:0]         restock_code;
    logic [3:0]         restock_qty;
    logic [2:0]         query_code;
    logic [STOCK_W-1:0] query_stock;
    logic [2:0]         motor_sel;
    logic               motor_pulse;
    logic               busy;
    logic               done;
    logic               err_stock;
`ifdef DISPENSE_SALES_COUNTER_EN
    logic [15:0]        total_sold;

    modport master (
        output req_valid, item_code, item_count, restock_valid, restock_code, restock_qty, query_code,
        input  req_ready, query_stock, motor_sel, motor_pulse, busy, done, err_stock, total_sold
    );
    modport slave (
        input  req_valid, item_code, item_count, restock_valid, restock_code, restock_qty, query_code,
        output req_ready, query_stock, motor_sel, motor_pulse, busy, done, err_stock, total_sold
    );
`else
    modport master (
        output req_valid, item_code, item_count, restock_valid, restock_code, restock_qty, query_code,
        input  req_ready, query_stock, motor_sel, motor_pulse, busy, done, err_stock
    );
    modport slave (
        input  req_valid, item_code, item_count, restock_valid, restock_code, restock_qty, query_code,
        output req_ready, query_stock, motor_sel, motor_pulse, busy, done, err_stock
    );
`endif
endinterface

// File: rtl/dispense_controller.sv
// Accepts purchase requests, checks/decrements per-slot inventory and pulses the slot motor once per unit.
// Optional DISPENSE_SALES_COUNTER_EN adds a wrapping 16-bit count of dispensed units (total_sold).
module dispense_controller #(
    parameter int NUM_ITEMS    = 8,
    parameter int STOCK_W      = 8,
    parameter int STOCK_INIT   = 10,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic      clock,
    input  logic      reset,
    dispense_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int PHASE_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_t             state_r;
    state_t             nextState_s;
    logic [2:0]         code_r;
    logic [3:0]         count_r;
    logic [3:0]         remaining_r;
    logic [CNT_W-1:0]   phaseCnt_r;
    logic [STOCK_W-1:0] stock_r     [NUM_ITEMS];
    logic [STOCK_W-1:0] nextStock_s [NUM_ITEMS];
    logic               accept_s;
    logic               short_s;
    logic               pulseEnd_s;
    logic               deduct_s;

    // Deduction never underflows (guarded by the CHECK compare); only the restock can overflow and saturates.
    function automatic logic [STOCK_W-1:0] slotNext(
        input logic [STOCK_W-1:0] cur,
        input logic               take,
        input logic [3:0]         takeQty,
        input logic               add,
        input logic [3:0]         addQty
    );
        logic [STOCK_W:0] sum;
        sum = {1'b0, cur};
        if (take) begin
            sum = sum - (STOCK_W+1)'(takeQty);
        end
        if (add) begin
            sum = sum + (STOCK_W+1)'(addQty);
        end
        return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
    endfunction

    assign accept_s    = bus.req_valid && (state_r == IDLE);
    assign short_s     = stock_r[code_r] < STOCK_W'(count_r);
    assign pulseEnd_s  = (state_r == PULSE) && (phaseCnt_r == PULSE_LAST);
    assign deduct_s    = (state_r == CHECK) && (count_r != 4'd0) && !short_s;
    assign bus.query_stock = stock_r[bus.query_code];
    assign bus.motor_sel   = code_r;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decision.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:  if (accept_s) nextState_s = CHECK; else nextState_s = IDLE;
            CHECK: begin
                if (count_r == 4'd0) begin
                    nextState_s = DONE;
                end else if (short_s) begin
                    nextState_s = ERR;
                end else begin
                    nextState_s = PULSE;
                end
            end
            PULSE: begin
                if (pulseEnd_s) begin
                    if (remaining_r == 4'd1) nextState_s = DONE; else nextState_s = GAP;
                end else begin
                    nextState_s = PULSE;
                end
            end
            GAP:   if (phaseCnt_r == GAP_LAST) nextState_s = PULSE; else nextState_s = GAP;
            DONE:  nextState_s = IDLE;
            ERR:   nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        bus.req_ready   = 1'b0;
        bus.busy        = 1'b0;
        bus.motor_pulse = 1'b0;
        bus.done        = 1'b0;
        bus.err_stock   = 1'b0;
        case (state_r)
            IDLE:  bus.req_ready = 1'b1;
            CHECK: bus.busy = 1'b1;
            PULSE: begin
                bus.busy        = 1'b1;
                bus.motor_pulse = 1'b1;
            end
            GAP:   bus.busy = 1'b1;
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            ERR: begin
                bus.busy      = 1'b1;
                bus.err_stock = 1'b1;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

    // Request latch, units-left counter and pulse/gap phase timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_r      <= 3'd0;
            count_r     <= 4'd0;
            remaining_r <= 4'd0;
            phaseCnt_r  <= '0;
        end else begin
            if (accept_s) begin
                code_r  <= bus.item_code;
                count_r <= bus.item_count;
            end
            if (state_r == CHECK) begin
                remaining_r <= count_r;
            end else if (pulseEnd_s) begin
                remaining_r <= remaining_r - 4'd1;
            end
            if (((state_r == PULSE) || (state_r == GAP)) && (nextState_s == state_r)) begin
                phaseCnt_r <= phaseCnt_r + CNT_W'(1);
            end else begin
                phaseCnt_r <= '0;
            end
        end
    end

    // Same-slot deduction and restock in one cycle combine as sat(stock - count + qty).
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            nextStock_s[i] = slotNext(stock_r[i],
                                      deduct_s && (code_r == 3'(i)), count_r,
                                      bus.restock_valid && (bus.restock_code == 3'(i)), bus.restock_qty);
        end
    end

    // Inventory table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= nextStock_s[i];
            end
        end
    end

`ifdef DISPENSE_SALES_COUNTER_EN
    logic [15:0] totalSold_r;
    assign bus.total_sold = totalSold_r;

    // Units dispensed, counted as each pulse window completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            totalSold_r <= 16'd0;
        end else if (pulseEnd_s) begin
            totalSold_r <= totalSold_r + 16'd1;
        end else begin
            totalSold_r <= totalSold_r;
        end
    end
`endif
endmodule
